// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode and direction constants for the universal shift register
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_bit_counter.sv
// rtl/usr_bit_counter.sv - modulo-WIDTH bit counter with registered wrap strobe
module usr_bit_counter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_wrap;

    // Strobe is cleared on every edge so it lasts exactly one cycle, even if the
    // following edge is not enabled; a clear on the last count suppresses it.
    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_inc) begin
                if (r_count == LAST) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - parametrised shift/rotate/load register with word framing
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Enable_In,
    input  logic [2:0]       Mode_In,
    input  logic             Serial_Data_In,
    input  logic [WIDTH-1:0] Parallel_Data_In,
    output logic             Serial_Data_Out,
    output logic [WIDTH-1:0] Parallel_Data_Out,
    output logic [CNT_W-1:0] Bit_Count_Out,
    output logic             Word_Done_Out
);

    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic [WIDTH-1:0] w_next_data;
    logic             w_next_dir;
    logic             w_shift;
    logic             w_zero;

    always_comb begin
        w_next_data = r_data;
        w_next_dir  = r_dir;
        w_shift     = 1'b0;
        w_zero      = 1'b0;
        case (Mode_In)
            MODE_SHR: begin
                w_next_data = {Serial_Data_In, r_data[WIDTH-1:1]};
                w_next_dir  = DIR_RIGHT;
                w_shift     = 1'b1;
            end
            MODE_SHL: begin
                w_next_data = {r_data[WIDTH-2:0], Serial_Data_In};
                w_next_dir  = DIR_LEFT;
                w_shift     = 1'b1;
            end
            MODE_ROR: begin
                w_next_data = {r_data[0], r_data[WIDTH-1:1]};
                w_next_dir  = DIR_RIGHT;
                w_shift     = 1'b1;
            end
            MODE_ROL: begin
                w_next_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                w_next_dir  = DIR_LEFT;
                w_shift     = 1'b1;
            end
            MODE_LOAD: begin
                w_next_data = Parallel_Data_In;
                w_zero      = 1'b1;
            end
            MODE_CLEAR: begin
                w_next_data = '0;
                w_zero      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_data <= '0;
            r_dir  <= DIR_RIGHT;
        end else if (Enable_In) begin
            r_data <= w_next_data;
            r_dir  <= w_next_dir;
        end
    end

    usr_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .i_clk   (Clk_In),
        .i_rst   (Reset_In),
        .i_inc   (Enable_In & w_shift),
        .i_clr   (Enable_In & w_zero),
        .o_count (Bit_Count_Out),
        .o_wrap  (Word_Done_Out)
    );

    // Exit bit follows the last shift direction, never the current Mode_In.
    assign Serial_Data_Out   = (r_dir == DIR_LEFT) ? r_data[WIDTH-1] : r_data[0];
    assign Parallel_Data_Out = r_data;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - randomized scoreboard bench for universal_shift_register
module tb_universal_shift_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic         sin = 1'b0;
    logic [W-1:0] pin = '0;
    logic         sout;
    logic [W-1:0] pout;
    logic [2:0]   cnt;
    logic         done;

    universal_shift_register #(.WIDTH(W)) dut (
        .Clk_In            (clk),
        .Reset_In          (rst),
        .Enable_In         (en),
        .Mode_In           (mode),
        .Serial_Data_In    (sin),
        .Parallel_Data_In  (pin),
        .Serial_Data_Out   (sout),
        .Parallel_Data_Out (pout),
        .Bit_Count_Out     (cnt),
        .Word_Done_Out     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           count;
        logic         done;
        logic         sout;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_strobes = 0;

    logic [W-1:0] m_data;
    int           m_count;
    logic         m_left;
    logic         m_done;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_count = 0;
        m_left  = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic step(input logic e, input logic [2:0] md, input logic s, input logic [W-1:0] p);
        exp_t x;
        @(posedge clk);
        #1;
        en = e; mode = md; sin = s; pin = p;
        m_done = 1'b0;
        if (e) begin
            case (md)
                3'd1: begin m_data = (m_data >> 1) | (8'(s) << (W - 1)); m_left = 1'b0; end
                3'd2: begin m_data = (m_data << 1) | 8'(s);               m_left = 1'b1; end
                3'd3: begin m_data = (m_data >> 1) | (m_data << (W - 1)); m_left = 1'b0; end
                3'd4: begin m_data = (m_data << 1) | (m_data >> (W - 1)); m_left = 1'b1; end
                3'd5: m_data = p;
                3'd6: m_data = '0;
                default: ;
            endcase
            if (md >= 3'd1 && md <= 3'd4) begin
                m_count = (m_count + 1) % W;
                m_done  = (m_count == 0);
            end else if (md == 3'd5 || md == 3'd6) begin
                m_count = 0;
            end
        end
        x.data  = m_data;
        x.count = m_count;
        x.done  = m_done;
        x.sout  = m_left ? m_data[W-1] : m_data[0];
        q.push_back(x);
    endtask

    // Idle edge, then the DUT shows the state produced by the previous operation.
    task automatic idle();
        step(1'b0, 3'd1, 1'b0, '0);
    endtask

    always @(posedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("data", 64'(pout), 64'(e.data));
            chk("count", 64'(cnt), 64'(e.count));
            chk("done", 64'(done), 64'(e.done));
            chk("sout", 64'(sout), 64'(e.sout));
            if (done) n_strobes++;
        end
    end

    task automatic async_reset();
        @(posedge clk);
        #1;
        en = 1'b1; mode = 3'd1;
        rst = 1'b1;
        #1;
        chk("rst_data", 64'(pout), 64'h0);
        chk("rst_count", 64'(cnt), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_sout", 64'(sout), 64'h0);
        @(posedge clk);
        #1;
        en = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        model_reset();
        @(posedge clk);
        #1;
        chk("init_data", 64'(pout), 64'h0);
        chk("init_count", 64'(cnt), 64'h0);
        chk("init_done", 64'(done), 64'h0);
        chk("init_sout", 64'(sout), 64'h0);
        rst = 1'b0;

        step(1'b1, 3'd5, 1'b0, 8'hA5);
        s0 = n_strobes;
        for (int i = 0; i < W; i++) step(1'b1, 3'd1, 1'b1, '0);
        idle();
        chk("shr_final", 64'(pout), 64'hFF);
        idle();
        chk("shr_strobes", 64'(n_strobes - s0), 64'd1);

        step(1'b1, 3'd5, 1'b0, 8'h81);
        step(1'b1, 3'd4, 1'b0, '0);
        idle();
        chk("rol", 64'(pout), 64'h03);
        step(1'b1, 3'd3, 1'b0, '0);
        step(1'b1, 3'd3, 1'b0, '0);
        idle();
        chk("ror", 64'(pout), 64'hC0);
        chk("ror_count", 64'(cnt), 64'd3);

        step(1'b1, 3'd5, 1'b0, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 1'b0, '0);
        idle();
        chk("shl", 64'(pout), 64'h08);

        for (int i = 0; i < 5; i++) step(1'b0, 3'd1, 1'b1, '0);
        step(1'b1, 3'd7, 1'b1, 8'hFF);
        step(1'b1, 3'd7, 1'b0, 8'hFF);
        idle();
        chk("hold_data", 64'(pout), 64'h08);
        chk("hold_count", 64'(cnt), 64'd3);

        step(1'b1, 3'd6, 1'b0, '0);
        s0 = n_strobes;
        for (int i = 0; i < W - 1; i++) step(1'b1, 3'd1, 1'b1, '0);
        step(1'b1, 3'd5, 1'b0, 8'h3C);
        idle();
        chk("load_last", 64'(pout), 64'h3C);
        chk("load_last_strobes", 64'(n_strobes - s0), 64'd0);
        for (int i = 0; i < W; i++) step(1'b1, 3'd3, 1'b0, '0);
        idle();
        idle();
        chk("ror8", 64'(pout), 64'h3C);
        chk("ror8_strobes", 64'(n_strobes - s0), 64'd1);

        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 1'b1, '0);
        async_reset();

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom), 8'($urandom));
            if (i == 200) async_reset();
        end
        idle();
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the fixed 32-bit serial-in/serial-out register.
- Modes: hold, shift right, shift left, rotate right, rotate left, parallel load and clear, selected per cycle.
- A bit counter and a one-cycle word-complete strobe let a serial link or deserialiser frame WIDTH-bit words without external counting.
- Sits between serial pins or bus logic and word-wide datapaths.

Parameters:
- WIDTH, 32, register length in bits (legal range 2..64).
- CNT_W, $clog2(WIDTH), width of the bit counter (localparam, not overridable).

Ports:
- Clk_In  input  1  clock; all state updates on the falling edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  when 0, all state holds regardless of Mode_In.
- Mode_In  input  3  operation select (encoding below).
- Serial_Data_In  input  1  serial bit entering on shift operations.
- Parallel_Data_In  input  WIDTH  word captured on parallel load.
- Serial_Data_Out  output  1  bit currently at the exit end of the register.
- Parallel_Data_Out  output  WIDTH  register contents.
- Bit_Count_Out  output  CNT_W  shifts/rotates since the last load, clear or wrap.
- Word_Done_Out  output  1  one-cycle strobe at the completion of WIDTH shifts/rotates.

Behaviour:
- Reset (asynchronous, any time, including mid-word):
  - Register = 0, Bit_Count_Out = 0, Word_Done_Out = 0, direction flag = RIGHT.
  - Reset takes precedence over every mode.
- All other state changes on the falling edge of Clk_In, only when Enable_In = 1.
- Mode encoding, R = register:
  - 000 HOLD: R unchanged.
  - 001 SHR: R <= {Serial_Data_In, R[WIDTH-1:1]}.
  - 010 SHL: R <= {R[WIDTH-2:0], Serial_Data_In}.
  - 011 ROR: R <= {R[0], R[WIDTH-1:1]}.
  - 100 ROL: R <= {R[WIDTH-2:0], R[WIDTH-1]}.
  - 101 LOAD: R <= Parallel_Data_In.
  - 110 CLEAR: R <= 0.
  - 111 reserved; behaves as HOLD.
- Direction flag (registered):
  - SHR and ROR set it to RIGHT; SHL and ROL set it to LEFT.
  - All other modes leave it unchanged.
- Serial_Data_Out is combinational from registered state only: R[0] when the flag is RIGHT, R[WIDTH-1] when LEFT.
  - It is never decoded from Mode_In directly.
  - After reset it equals R[0] = 0.
- Bit counter:
  - SHR, SHL, ROR and ROL increment it. At WIDTH-1 an increment wraps it to 0.
  - LOAD and CLEAR force it to 0.
  - HOLD, reserved mode and Enable_In = 0 leave it unchanged.
- Word_Done_Out:
  - Registered; it is 1 for exactly the cycle following an edge on which the counter wrapped from WIDTH-1 to 0. Otherwise 0.
  - LOAD or CLEAR on the edge where the count is WIDTH-1 suppresses the strobe.
  - Consecutive words produce strobes exactly WIDTH enabled-shift edges apart.
- Latency:
  - Parallel_Data_Out reflects an operation one edge after it is issued.
  - With continuous SHR, a bit applied at Serial_Data_In appears at Serial_Data_Out after WIDTH edges.
- Mixed directions within a word still count toward the same word; the counter does not reset on a direction change.
- Reset mid-word discards the partial count; no strobe is generated.

Decomposition:
- Shared package usr_pkg holds:
  - mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_CLEAR;
  - direction constants DIR_RIGHT = 0 and DIR_LEFT = 1.
- One sub-module is natural: usr_bit_counter, a modulo-WIDTH counter with inc, clear and wrap-strobe outputs. It is reusable by future PISO/SIPO blocks.
- The shift datapath stays in the top module.

Test Plan (WIDTH = 8):
- Reset -> Parallel_Data_Out = 8'h00, Serial_Data_Out = 0, Bit_Count_Out = 0, Word_Done_Out = 0. Assert Reset_In mid-shift -> all return to 0 immediately, with no clock edge needed.
- LOAD 8'hA5, then 8 x SHR with Serial_Data_In = 1:
  - Serial_Data_Out sequence is 1,0,1,0,0,1,0,1 (LSB first).
  - Final register = 8'hFF.
  - Word_Done_Out pulses once, in the cycle after the 8th edge.
- LOAD 8'h81, then ROL x 1 -> 8'h03; then ROR x 2 -> 8'hC0; Bit_Count_Out = 3; Serial_Data_Out = R[0] = 0 after the RORs.
- LOAD 8'h01, then SHL x 3 with Serial_Data_In = 0 -> 8'h08. Serial_Data_Out tracks R[7] = 0; Bit_Count_Out = 3.
- Enable_In = 0 with Mode_In = SHR for 5 edges -> register, counter and flag unchanged. Mode 111 with Enable_In = 1 -> also unchanged.
- 7 x SHR, then LOAD 8'h3C on the 8th edge -> no Word_Done_Out pulse, Bit_Count_Out = 0, register = 8'h3C. Then 8 x ROR -> register back to 8'h3C with exactly one strobe.
